// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Two-port round-robin arbiter in front of a single-ported, word-organised
// data memory. A pipeline port (p_*) and a debug/DMA port (d_*) issue byte,
// halfword or word loads and stores. The arbiter latches the winning request,
// drives one memory cycle with lane enables and replicated store data, and
// returns aligned, sign/zero-extended load data to the requester.
//
// Parameters
//   DM_ADDRESS : data-memory byte-address width
//   DATA_W     : data width (only 32 is supported)
//
// Ports
//   clk, reset           : single clock, asynchronous active-high reset
//   x_req/we/funct3/     : request side, x in {p, d}
//   x_addr/x_wdata
//   x_gnt                : one-cycle pulse, request latched
//   x_rvalid, x_rdata    : load response pulse and held load data
//   x_err                : misalignment trap pulse (optional build only)
//   m_addr/re/we/be/     : memory side, word address and strobes
//   m_wdata, m_rdata       (m_rdata valid the cycle after m_re)
//   dbg_state            : current FSM state, for observation
//
// Build option
//   DMEM_ARB_MISALIGN_TRAP_EN : when defined, adds p_err/d_err and traps
//   misaligned H/W accesses instead of silently ignoring the low bits.
//
// Handshake: a requester raises x_req with stable we/funct3/addr/wdata and
// holds all of them until it sees x_gnt; the fields are latched on the edge
// that starts the x_gnt cycle, so the requester may drop or change them during
// that cycle. Loads answer with a one-cycle x_rvalid; there is no back-pressure.

module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [2:0]            p_funct3,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  output logic                  p_gnt,
  output logic                  p_rvalid,
  output logic [DATA_W-1:0]     p_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  output logic                  p_err,
  output logic                  d_err,
`endif

  output logic [DM_ADDRESS-1:0] m_addr,
  output logic                  m_re,
  output logic                  m_we,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,

  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;

  // funct3[1:0]: 00 byte, 01 half, anything else word; funct3[2] = unsigned.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // last_d = 1 means d won the most recent grant, so p wins the next tie.
  logic last_d;
  logic pick_d;
  assign pick_d = d_req & (~p_req | ~last_d);

  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  assign sel_we    = pick_d ? d_we     : p_we;
  assign sel_f3    = pick_d ? d_funct3 : p_funct3;
  assign sel_addr  = pick_d ? d_addr   : p_addr;
  assign sel_wdata = pick_d ? d_wdata  : p_wdata;

  logic sel_mis;
  logic lat_mis;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction
  assign sel_mis = misaligned(sel_f3, sel_addr[1:0]);
`else
  // Low address bits beyond the access size are simply ignored.
  assign sel_mis = 1'b0;
`endif

  // Latched access attributes for the WAIT/RESP phases.
  logic       cur_d;
  logic       lat_we;
  logic [2:0] lat_f3;
  logic [1:0] lat_alo;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      cur_d    <= 1'b0;
      lat_we   <= 1'b0;
      lat_f3   <= 3'b000;
      lat_alo  <= 2'b00;
      lat_mis  <= 1'b0;
      p_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      p_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      p_rdata  <= '0;
      d_rdata  <= '0;
      m_addr   <= '0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'b0000;
      m_wdata  <= '0;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      p_err    <= 1'b0;
      d_err    <= 1'b0;
`endif
    end else begin
      // Pulses and strobes default low; each is raised for one state only.
      p_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      p_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'b0000;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      p_err    <= 1'b0;
      d_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (p_req || d_req) begin
            state   <= ISSUE;
            cur_d   <= pick_d;
            last_d  <= pick_d;
            p_gnt   <= ~pick_d;
            d_gnt   <= pick_d;
            lat_we  <= sel_we;
            lat_f3  <= sel_f3;
            lat_alo <= sel_addr[1:0];
            lat_mis <= sel_mis;
            m_addr  <= {sel_addr[DM_ADDRESS-1:2], 2'b00};
            m_wdata <= sel_we ? lane_data(sel_f3, sel_wdata) : '0;
            if (!sel_mis) begin
              m_we <= sel_we;
              m_re <= ~sel_we;
              m_be <= sel_we ? store_be(sel_f3, sel_addr[1:0]) : 4'b0000;
            end
          end
        end
        ISSUE: begin
          if (lat_mis) begin
            // Trapped access: no memory cycle, report straight away.
            state <= RESP;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
            if (cur_d) begin
              d_err <= 1'b1;
              if (!lat_we) begin
                d_rvalid <= 1'b1;
                d_rdata  <= '0;
              end
            end else begin
              p_err <= 1'b1;
              if (!lat_we) begin
                p_rvalid <= 1'b1;
                p_rdata  <= '0;
              end
            end
`endif
          end else if (lat_we) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // m_rdata belongs to the read issued in the previous cycle.
          state <= RESP;
          if (cur_d) begin
            d_rvalid <= 1'b1;
            d_rdata  <= load_extract(lat_f3, lat_alo, m_rdata);
          end else begin
            p_rvalid <= 1'b1;
            p_rdata  <= load_extract(lat_f3, lat_alo, m_rdata);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//
// Bench for dmem_port_arbiter. A byte-array reference model predicts, for each
// access in grant order, the memory-side issue cycle and the load response.
// A monitor compares the DUT against those queued predictions whenever a
// grant or response appears. A separate word-organised memory responds to the
// DUT's strobes, so lane enables and replicated data are exercised end to end.
// Honours DMEM_ARB_MISALIGN_TRAP_EN the same way the design does.

module tb_dmem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int IW = 1 + AW + 1 + 1 + 4 + 32;               // issue record
  localparam int RW = 1 + 1 + 1 + 2 + 32;                    // response record
  localparam int OW = 3 * DW + AW + 14;                      // all outputs

  typedef struct packed {
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } txn_t;

  // clock / reset
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          p_req, p_we, d_req, d_we;
  logic [2:0]    p_funct3, d_funct3;
  logic [AW-1:0] p_addr, d_addr;
  logic [DW-1:0] p_wdata, d_wdata;
  logic          p_gnt, p_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] p_rdata, d_rdata;
  logic [AW-1:0] m_addr;
  logic          m_re, m_we;
  logic [3:0]    m_be;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    dbg_state;
  logic          p_err_s, d_err_s;

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_funct3(p_funct3), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    .p_err(p_err_s), .d_err(d_err_s),
`endif
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_be(m_be),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

`ifndef DMEM_ARB_MISALIGN_TRAP_EN
  assign p_err_s = 1'b0;
  assign d_err_s = 1'b0;
`endif

  logic [OW-1:0] all_out;
  assign all_out = {p_gnt, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_re, m_we,
                    m_be, m_wdata, p_err_s, d_err_s, dbg_state};

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_issue_q[$];
  logic [RW-1:0] exp_resp_q[$];
  logic          grant_log[$];
  logic [7:0]    ref_mem[0:511];
  logic [31:0]   mem_w[0:127];
  logic          model_last_d;
  int            cyc;
  int            gnt_cyc[2];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                              input logic [31:0] w);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = a; t.wdata = w;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)),
              AW'($urandom_range(0, 511)), $urandom);
  endfunction

  // Reference model: one access applied to the byte memory, pushing the
  // expected memory cycle and (for loads / traps) the expected response.
  task automatic model_access(input logic who, input txn_t t, input bit want_resp);
    int unsigned n, base, a;
    logic mis;
    logic [3:0]  be;
    logic [31:0] rep, val;
    n = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
    a = 32'(t.addr);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    mis = (a % n) != 0;
`else
    mis = 1'b0;
`endif
    base = (a / n) * n;
    be = 4'b0000; rep = 32'h0; val = 32'h0;
    if (!mis) begin
      if (t.we) begin
        for (int k = 0; k < int'(n); k++) begin
          ref_mem[base + k] = t.wdata[8*k +: 8];
          be[(base + k) % 4] = 1'b1;
        end
        for (int l = 0; l < 4; l++) rep[8*l +: 8] = t.wdata[8*(l % int'(n)) +: 8];
      end else begin
        for (int k = 0; k < int'(n); k++) val[8*k +: 8] = ref_mem[base + k];
        if (!t.f3[2] && n < 4 && val[8*n-1])
          for (int b = 8 * int'(n); b < 32; b++) val[b] = 1'b1;
      end
    end
    exp_issue_q.push_back({who, AW'(base - base % 4), t.we & ~mis, ~t.we & ~mis, be,
                           (t.we && !mis) ? rep : 32'h0});
    if (want_resp && (!t.we || mis))
      exp_resp_q.push_back({who, ~t.we, mis, mis ? 2'd1 : 2'd2, val});
  endtask

  // driver tasks
  task automatic set_req(input logic who, input txn_t t);
    if (!who) begin
      p_req = 1'b1; p_we = t.we; p_funct3 = t.f3; p_addr = t.addr; p_wdata = t.wdata;
    end else begin
      d_req = 1'b1; d_we = t.we; d_funct3 = t.f3; d_addr = t.addr; d_wdata = t.wdata;
    end
  endtask

  task automatic wait_gnt(input logic who);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if ((who ? d_gnt : p_gnt) === 1'b1) begin
        got = 1;
        break;
      end
    end
    // Fields are scrambled after the grant; the DUT must already hold them.
    if (!who) begin
      p_req = 1'b0; p_we = 1'($urandom); p_funct3 = 3'($urandom); p_addr = AW'($urandom);
      p_wdata = $urandom;
    end else begin
      d_req = 1'b0; d_we = 1'($urandom); d_funct3 = 3'($urandom); d_addr = AW'($urandom);
      d_wdata = $urandom;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: requester %0d got no grant within 40 cycles", who);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_issue_q.size() == 0 && exp_resp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d issue and %0d responses still expected",
               exp_issue_q.size(), exp_resp_q.size());
      exp_issue_q.delete();
      exp_resp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_round(input bit p_en, input txn_t pt, input bit d_en, input txn_t dt);
    if (p_en && d_en) begin
      // A tie serves both in turn, so the pointer ends where it started.
      if (model_last_d) begin
        model_access(1'b0, pt, 1); model_access(1'b1, dt, 1);
      end else begin
        model_access(1'b1, dt, 1); model_access(1'b0, pt, 1);
      end
    end else if (p_en) begin
      model_access(1'b0, pt, 1); model_last_d = 1'b0;
    end else if (d_en) begin
      model_access(1'b1, dt, 1); model_last_d = 1'b1;
    end
    if (p_en) set_req(1'b0, pt);
    if (d_en) set_req(1'b1, dt);
    fork
      begin if (p_en) wait_gnt(1'b0); end
      begin if (d_en) wait_gnt(1'b1); end
    join
    drain();
  endtask

  task automatic reset_mid_load();
    txn_t t;
    bit seen;
    t = mk(1'b0, 3'b010, 9'h020, 32'h0);
    model_access(1'b1, t, 0);
    set_req(1'b1, t);
    wait_gnt(1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: outputs %h expected all zero", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    model_last_d = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_rvalid === 1'b1) seen = 1;
    end
    check_val("no_rvalid_after_reset", {31'h0, seen}, 32'h0);
  endtask

  // memory responder: applies strobes, keeps read data only for the cycle after m_re
  initial begin : mem_slave
    logic prev_re;
    prev_re = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_we)
          for (int l = 0; l < 4; l++)
            if (m_be[l]) mem_w[m_addr[AW-1:2]][8*l +: 8] = m_wdata[8*l +: 8];
        if (m_re) m_rdata = mem_w[m_addr[AW-1:2]];
        else if (!prev_re) m_rdata = $urandom;
        prev_re = m_re;
      end else begin
        prev_re = 1'b0;
      end
    end
  end

  // monitor
  initial begin : monitor
    logic [IW-1:0] act_i, exp_i;
    logic [RW-1:0] act_r, exp_r;
    logic who, rv;
    int lat;
    cyc = 0;
    gnt_cyc[0] = 0;
    gnt_cyc[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        checks++;
        if (p_gnt && d_gnt) begin
          errors++;
          $display("FAIL dual_gnt: both grants high at cycle %0d", cyc);
        end
        if (p_gnt || d_gnt) begin
          who = d_gnt;
          gnt_cyc[who] = cyc;
          grant_log.push_back(who);
          act_i = {who, m_addr, m_we, m_re, m_be, m_we ? m_wdata : 32'h0};
          checks++;
          if (exp_issue_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got %h", act_i);
          end else begin
            exp_i = exp_issue_q.pop_front();
            if (act_i !== exp_i) begin
              errors++;
              $display("FAIL issue: got %h expected %h", act_i, exp_i);
            end
          end
        end else begin
          checks++;
          if (m_re || m_we || m_be != 4'b0000) begin
            errors++;
            $display("FAIL strobe_idle: re %b we %b be %b expected 0 0 0000", m_re, m_we, m_be);
          end
        end
        if (p_rvalid || p_err_s || d_rvalid || d_err_s) begin
          who = d_rvalid || d_err_s;
          rv = who ? d_rvalid : p_rvalid;
          lat = cyc - gnt_cyc[who];
          act_r = {who, rv, who ? d_err_s : p_err_s, lat[1:0],
                   rv ? (who ? d_rdata : p_rdata) : 32'h0};
          checks++;
          if (exp_resp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got %h", act_r);
          end else begin
            exp_r = exp_resp_q.pop_front();
            if (act_r !== exp_r) begin
              errors++;
              $display("FAIL resp: got %h expected %h", act_r, exp_r);
            end
          end
        end
      end
    end
  end

  // main stimulus
  initial begin : main
    txn_t none;
    logic exp_order[4];
    logic [31:0] w4;
    none = mk(1'b0, 3'b000, '0, 32'h0);
    reset = 1'b1;
    p_req = 1'b0; p_we = 1'b0; p_funct3 = 3'b000; p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = '0; d_wdata = '0;
    model_last_d = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 8'($urandom_range(0, 255));
      mem_w[i / 4][(i % 4) * 8 +: 8] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected all zero", all_out);
    end
    reset = 1'b0;
    @(negedge clk);

    // word store
    run_round(1, mk(1'b1, 3'b010, 9'h010, 32'hDEADBEEF), 0, none);

    // byte store then signed / unsigned byte loads of the same byte
    run_round(1, mk(1'b1, 3'b010, 9'h010, 32'h00000000), 0, none);
    run_round(1, mk(1'b1, 3'b000, 9'h013, 32'h000000A5), 0, none);
    run_round(1, mk(1'b0, 3'b000, 9'h013, 32'h0), 0, none);
    check_val("lb_rdata", p_rdata, 32'hFFFFFFA5);
    run_round(1, mk(1'b0, 3'b100, 9'h013, 32'h0), 0, none);
    check_val("lbu_rdata", p_rdata, 32'h000000A5);

    // reset while a d load waits for memory
    reset_mid_load();

    // simultaneous requests: p, d, p, d
    grant_log.delete();
    run_round(1, rnd_txn(), 1, rnd_txn());
    run_round(1, rnd_txn(), 1, rnd_txn());
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    check_val("tie_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_val($sformatf("tie_grant_%0d", i), {31'h0, grant_log[i]}, {31'h0, exp_order[i]});

    // misaligned word load
    w4 = {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]};
    run_round(1, mk(1'b0, 3'b010, 9'h006, 32'h0), 0, none);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    check_val("lw_misaligned_rdata", p_rdata, 32'h0);
`else
    check_val("lw_misaligned_rdata", p_rdata, w4);
`endif

    // randomized traffic
    for (int r = 0; r < 80; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], rnd_txn(), sel[1], rnd_txn());
    end

    check_val("queues_empty", 32'(exp_issue_q.size() + exp_resp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
